// File: rtl/pipe_stage_skid.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_stage_skid                                            |
// | Description : Elastic pipeline-stage register with a 2-entry skid        |
// |               buffer, registered in_ready, synchronous flush, occupancy  |
// |               output and a saturating flush-drop counter.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pipe_stage_skid #(
   parameter int                DATA_W      = 128,
   parameter int                CTRL_W      = 10,
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
   parameter int                CNT_W       = 16     // must be >= 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  drop_count
);

   // The state encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_main_data;
   logic [CTRL_W-1:0]   r_main_ctrl;
   logic [DATA_W-1:0]   r_skid_data;
   logic [CTRL_W-1:0]   r_skid_ctrl;
   logic [CNT_W-1:0]    r_drop_count;

   logic                w_in_fire;
   logic                w_out_fire;
   logic                w_load_main_in;
   logic                w_load_main_skid;
   logic                w_load_skid;
   logic [1:0]          w_drop_inc;
   logic [CNT_W:0]      w_drop_sum;

   // Handshake status depends only on registered state (plus reset mask).
   assign in_ready   = (r_state != ST_TWO) & ~rst;
   assign out_valid  = (r_state != ST_EMPTY);
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = out_valid & out_ready;

   assign out_data   = r_main_data;
   assign out_ctrl   = out_valid ? r_main_ctrl : CTRL_BUBBLE;
   assign occupancy  = r_state;
   assign drop_count = r_drop_count;

   // Entries lost to a flush: everything held, minus what the consumer took,
   // plus whatever was accepted in the same cycle. Range is 0..2.
   assign w_drop_inc = r_state - {1'b0, w_out_fire} + {1'b0, w_in_fire};
   assign w_drop_sum = {1'b0, r_drop_count} + {{(CNT_W-1){1'b0}}, w_drop_inc};

   // Next-state and register-load selection; flush overrides normal flow.
   always_comb begin
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  w_load_main_in = 1'b1;
                  w_state_nxt    = ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  w_load_main_in = 1'b1;
               end else if (w_in_fire) begin
                  w_load_skid = 1'b1;
                  w_state_nxt = ST_TWO;
               end else if (w_out_fire) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (w_out_fire) begin
                  w_load_main_skid = 1'b1;
                  w_state_nxt      = ST_ONE;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_state_nxt;
   end

   // Main (head) and skid entry registers; data survives flush untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_main_data <= '0;
         r_main_ctrl <= CTRL_BUBBLE;
         r_skid_data <= '0;
         r_skid_ctrl <= CTRL_BUBBLE;
      end else begin
         if (w_load_main_in) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
         end else if (w_load_main_skid) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
         end
         if (w_load_skid) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
         end
      end
   end

   // Saturating count of entries discarded by flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_drop_count <= '0;
      end else if (flush) begin
         r_drop_count <= w_drop_sum[CNT_W] ? C_CNT_MAX : w_drop_sum[CNT_W-1:0];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pipe_stage_skid                                         |
// | Description : Scoreboard bench for pipe_stage_skid. A queue-based model  |
// |               of the held entries predicts every output; a wide-counter  |
// |               and a 2-bit-counter instance share the same stimulus.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pipe_stage_skid;

   localparam int          DW     = 32;
   localparam int          CW     = 10;
   localparam logic [9:0]  BUBBLE = 10'h155;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;
   logic          out_ready = 1'b0;

   logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid;
   logic [DW-1:0] a_out_data, b_out_data;
   logic [CW-1:0] a_out_ctrl, b_out_ctrl;
   logic [1:0]    a_occ, b_occ;
   logic [15:0]   a_drop;
   logic [1:0]    b_drop;

   int            n_chk  = 0;
   int            n_pass = 0;
   bit            started  = 1'b0;
   bit            acc_flag = 1'b0;

   ent_t          q[$];
   longint        raw_drops = 0;
   logic [DW-1:0] last_data = '0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUBBLE), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
      .occupancy(a_occ), .drop_count(a_drop)
   );

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUBBLE), .CNT_W(2)) u_dut_sat (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
      .occupancy(b_occ), .drop_count(b_drop)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Monitor + reference model: checks outputs mid-cycle, then advances the
   // model by the transfers that will happen at the coming rising edge.
   initial begin
      ent_t        head;
      bit          e_valid, e_rdy, m_in_fire, m_out_fire;
      logic [CW-1:0] e_ctrl;
      logic [DW-1:0] e_data;
      wait (started);
      forever begin
         @(negedge clk);
         e_valid = (q.size() != 0);
         e_rdy   = !rst && (q.size() < 2);
         if (e_valid) begin
            head      = q[0];
            e_data    = head.d;
            e_ctrl    = head.c;
            last_data = head.d;
         end else begin
            e_data = last_data;
            e_ctrl = BUBBLE;
         end
         chk("occupancy",     64'(a_occ),       64'(q.size()));
         chk("in_ready",      64'(a_in_ready),  64'(e_rdy));
         chk("out_valid",     64'(a_out_valid), 64'(e_valid));
         chk("out_data",      64'(a_out_data),  64'(e_data));
         chk("out_ctrl",      64'(a_out_ctrl),  64'(e_ctrl));
         chk("drop_count",    64'(a_drop),      (raw_drops > 65535) ? 64'd65535 : 64'(raw_drops));
         chk("sat_occupancy", 64'(b_occ),       64'(q.size()));
         chk("sat_in_ready",  64'(b_in_ready),  64'(e_rdy));
         chk("sat_out_ctrl",  64'(b_out_ctrl),  64'(e_ctrl));
         chk("sat_out_data",  64'(b_out_data),  64'(e_data));
         chk("sat_out_valid", 64'(b_out_valid), 64'(e_valid));
         chk("sat_drop_count",64'(b_drop),      (raw_drops > 3) ? 64'd3 : 64'(raw_drops));

         m_in_fire  = in_valid && e_rdy;
         m_out_fire = e_valid && out_ready;
         acc_flag   = m_in_fire;
         if (rst) begin
            q.delete();
            raw_drops = 0;
            last_data = '0;
         end else begin
            if (m_out_fire) begin
               head = q.pop_front();
               chk("consumed_data", 64'(a_out_data), 64'(head.d));
               chk("consumed_ctrl", 64'(a_out_ctrl), 64'(head.c));
            end
            if (flush) begin
               raw_drops += q.size() + (m_in_fire ? 1 : 0);
               q.delete();
            end else if (m_in_fire) begin
               q.push_back('{d: in_data, c: in_ctrl});
            end
         end
      end
   end

   // One clock; an entry that was just accepted is withdrawn automatically.
   task automatic tick();
      @(posedge clk);
      #1;
      if (acc_flag) in_valid = 1'b0;
   endtask

   task automatic push(input logic [DW-1:0] d, input logic [CW-1:0] c);
      in_valid = 1'b1;
      in_data  = d;
      in_ctrl  = c;
      tick();
   endtask

   initial begin
      // 1: reset then a full-rate stream
      rst = 1'b1;
      tick();
      started = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) push(DW'(i), 10'h2A5);
      tick();

      // 2: backpressure into the skid, C waits, then drain in order
      out_ready = 1'b0;
      push(32'hA, 10'h001);
      push(32'hB, 10'h002);
      in_valid = 1'b1; in_data = 32'hC; in_ctrl = 10'h003;
      tick(); tick();
      out_ready = 1'b1;
      repeat (4) tick();

      // 3: flush with a full stage and a blocked input
      out_ready = 1'b0;
      push(32'h30, 10'h030);
      push(32'h31, 10'h031);
      in_valid = 1'b1; in_data = 32'h32; in_ctrl = 10'h032;
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      tick();

      // 4: flush while the head leaves and a new entry arrives
      push(32'h40, 10'h040);
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 32'h41; in_ctrl = 10'h041;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();

      // 5: saturation of the 2-bit counter: drops of 2, 2, 1
      rst = 1'b1; tick(); rst = 1'b0;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         push(32'h50 + DW'(k), 10'h050);
         if (k < 2) push(32'h60 + DW'(k), 10'h060);
         flush = 1'b1; tick(); flush = 1'b0;
         tick();
      end

      // 6: reset while full with a non-zero drop count
      push(32'h70, 10'h070);
      push(32'h71, 10'h071);
      rst = 1'b1; tick(); rst = 1'b0;
      tick();

      // Random traffic with occasional flush and reset
      for (int n = 0; n < 3000; n++) begin
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            in_ctrl  = CW'($urandom);
         end
         out_ready = (n % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         flush     = ($urandom_range(0, 19) == 0);
         rst       = ($urandom_range(0, 149) == 0);
         tick();
      end
      flush = 1'b0; rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, elastic pipeline-stage register for the datapath. It is the generic successor of the fixed-field inter-stage registers that carry pc, instruction, operands and decoded control.
- Carries one data bundle and one control bundle, with a valid/ready handshake on both sides.
- A 2-entry skid buffer keeps in_ready registered, so there is no combinational ready path through the stage.
- A synchronous flush inserts a bubble. An occupancy output and a saturating drop counter support hazard and performance debug.

Parameters:
DATA_W, 128, width of data bundle (pc, instruction, operands, immediate); carried unmodified.
CTRL_W, 10, width of control bundle (RegWrite, MemToReg, MemRead, MemWrite, ALUSrc, ALUOp, Branch, Jump).
CTRL_BUBBLE, {CTRL_W{1'b0}}, control value presented whenever the stage holds no valid entry.
CNT_W, 16, width of saturating flush-drop counter.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  synchronous kill of all held entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry; registered
in_data  input  DATA_W  upstream data bundle
in_ctrl  input  CTRL_W  upstream control bundle
out_valid  output  1  output entry valid
out_ready  input  1  downstream accepts the entry
out_data  output  DATA_W  head data bundle
out_ctrl  output  CTRL_W  head control bundle, or CTRL_BUBBLE when out_valid=0
occupancy  output  2  number of held entries (0..2)
drop_count  output  CNT_W  saturating count of entries killed by flush

Behaviour:
- Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage is a main register (head) plus a skid register. States are EMPTY (occ 0), ONE (occ 1) and TWO (occ 2). occupancy is the state encoding.
- in_ready = (state != TWO) & !rst. It is derived only from registered state.
- out_valid = (state != EMPTY).
- out_data and out_ctrl come from the main register.
- out_ctrl is forced to CTRL_BUBBLE when out_valid=0. out_data keeps its last loaded value; it is not cleared except by reset.
- Reset (rst=1 at the edge): state=EMPTY, main and skid data=0, main and skid ctrl=CTRL_BUBBLE, drop_count=0. After reset: out_valid=0, in_ready=1, occupancy=0. Reset mid-operation discards all entries without counting them.
- Priority: rst > flush > normal operation.
- EMPTY transitions:
  - in_fire: main <= in; next state ONE.
  - otherwise: stay EMPTY.
- ONE transitions:
  - in_fire & out_fire: main <= in; stay ONE.
  - in_fire & !out_fire: skid <= in; next state TWO.
  - !in_fire & out_fire: next state EMPTY.
  - otherwise: hold.
- TWO transitions:
  - in_ready=0, so no input is accepted.
  - out_fire: main <= skid; next state ONE.
  - otherwise: hold.
- Latency and throughput: an in_fire at edge N gives out_valid at edge N+1 (1 cycle). Sustained throughput is 1 entry per cycle while out_ready=1. Entries leave strictly in order.
- Flush cycle (flush=1 at the edge):
  - An out_fire in that cycle completes normally; the consumer has taken it.
  - All remaining held entries are discarded.
  - An in_fire in that cycle is accepted and discarded.
  - Next state is EMPTY, so next cycle out_valid=0, out_ctrl=CTRL_BUBBLE and in_ready=1.
  - drop_count += occupancy - out_fire + in_fire, saturating at all-ones.
  - Main data is not cleared.
- Flush asserted on consecutive cycles: each cycle re-empties the stage. Only entries actually accepted are counted.
- drop_count saturation: at 2^CNT_W-1 it holds and never wraps.
- No combinational path exists from out_ready or flush to in_ready.
- The only combinational path to out_ctrl is the valid mask.

Test Plan:
1. Reset then stream: rst=1 for 2 cycles, then in_valid=1 and out_ready=1 with in_ctrl=0x2A5 for entries 1..8. Required: in_ready=1 and occupancy=0 after reset; each entry appears on out_data one cycle after acceptance, in order; occupancy stays 1.
2. Backpressure/skid: with out_ready=0, push entries A and B. Required: occupancy 1 then 2; in_ready=0 in TWO; in_valid=1 holds C unaccepted. Then out_ready=1: output sequence is A, B, C with no loss or duplication.
3. Flush with full stage: state TWO, out_ready=0, in_valid=1, flush=1. Required: next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, in_ready=1, occupancy=0; drop_count increases by 2.
4. Flush with simultaneous transfers: state ONE, out_ready=1, in_valid=1, flush=1. Required: the head is consumed; the incoming entry is dropped; drop_count increases by 1; next cycle out_valid=0.
5. Drop counter saturation (CNT_W=2): issue repeated flushes with occupancy 2. Required: drop_count goes 2, then 3, then stays 3.
6. Reset mid-operation: state TWO with drop_count=5, then rst=1 for 1 cycle. Required: occupancy=0, drop_count=0, out_data=0, out_ctrl=CTRL_BUBBLE, in_ready=0 during rst and 1 after.
